// File: rtl/conv_seq_if.sv
// Handshake/bus bundle between the convolution sequencer and its datapath.
// master: sequencer side (drives SRAM, L0, MAC, SFU controls); slave: environment.
interface conv_seq_if #(
    parameter int AW = 7,
    parameter int KW = 4
);
    logic          start;
    logic          l0_full;
    logic [AW-1:0] I_A;
    logic          I_CEN;
    logic          I_WEN;
    logic          l0_wr;
    logic          l0_rd;
    logic [1:0]    inst_w;
    logic [AW-1:0] O_A;
    logic          O_CEN;
    logic          O_WEN;
    logic          sfu_rd;
    logic [KW-1:0] kij;
    logic          busy;
    logic          done;

    modport master (
        input  start, l0_full,
        output I_A, I_CEN, I_WEN, l0_wr, l0_rd, inst_w,
        output O_A, O_CEN, O_WEN, sfu_rd, kij, busy, done
    );

    modport slave (
        output start, l0_full,
        input  I_A, I_CEN, I_WEN, l0_wr, l0_rd, inst_w,
        input  O_A, O_CEN, O_WEN, sfu_rd, kij, busy, done
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution tile sequencer: per kernel position loads weights, runs them,
// loads/streams activations, then writes NP psums out and pulses done.
// Ports: clk, reset (async, active-high), bus (conv_seq_if.master).
module conv_seq_ctrl #(
    parameter int ROW      = 8,
    parameter int COL      = 8,
    parameter int KSIZE    = 3,
    parameter int IN_W     = 6,
    parameter int AW       = 7,
    parameter int ACT_BASE = 72,
    parameter int OUT_BASE = 0,
    parameter int WDRAIN   = 16,
    parameter int ADRAIN   = 18
) (
    input  logic       clk,
    input  logic       reset,
    conv_seq_if.master bus
);
    localparam int NK   = KSIZE * KSIZE;
    localparam int OW   = IN_W - KSIZE + 1;
    localparam int NP   = OW * OW;
    localparam int KW   = (NK > 1) ? $clog2(NK) : 1;
    localparam int RW   = (OW > 1) ? $clog2(OW) : 1;
    localparam int WEND = COL + WDRAIN;
    localparam int AEND = NP + ADRAIN;
    localparam int CM0  = (WEND > AEND) ? WEND : AEND;
    localparam int CMAX = (CM0 > ROW) ? CM0 : ROW;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, WGT_LD, WGT_EX, ACT_LD, ACT_EX, OUT_WR, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] r_q, r_d;
    logic [RW-1:0] c_q, c_d;
    logic [AW-1:0] roff_q, roff_d;
    logic [KW-1:0] kij_q, kij_d;
    logic [KW-1:0] kc_q, kc_d;
    logic [AW-1:0] koff_q, koff_d;
    logic [AW-1:0] wbase_q, wbase_d;
    logic          l0_wr_q, l0_wr_d;

    logic          rd_issue;
    logic [AW-1:0] i_a;
    logic          l0_rd;
    logic [1:0]    inst_w;
    logic          o_cen;
    logic          sfu_rd;
    logic          done;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        c_d      = c_q;
        roff_d   = roff_q;
        kij_d    = kij_q;
        kc_d     = kc_q;
        koff_d   = koff_q;
        wbase_d  = wbase_q;
        rd_issue = 1'b0;
        i_a      = wbase_q + AW'(cnt_q);
        l0_rd    = 1'b0;
        inst_w   = 2'b00;
        o_cen    = 1'b1;
        sfu_rd   = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = WGT_LD;
                    cnt_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                    roff_d  = '0;
                    kij_d   = '0;
                    kc_d    = '0;
                    koff_d  = '0;
                    wbase_d = '0;
                end
            end
            WGT_LD: begin
                if (!bus.l0_full) begin
                    rd_issue = 1'b1;
                    if (cnt_q == CW'(COL - 1)) begin
                        cnt_d   = '0;
                        state_d = WGT_EX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WGT_EX: begin
                if (cnt_q < CW'(COL)) begin
                    l0_rd  = 1'b1;
                    inst_w = 2'b01;
                end
                if (cnt_q == CW'(WEND - 1)) begin
                    cnt_d   = '0;
                    state_d = ACT_LD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACT_LD: begin
                // window origin + row offset + column, all modulo 2^AW
                i_a = AW'(ACT_BASE) + koff_q + roff_q + AW'(c_q);
                if (!bus.l0_full) begin
                    rd_issue = 1'b1;
                    if (c_q == RW'(OW - 1)) begin
                        c_d    = '0;
                        r_d    = r_q + 1'b1;
                        roff_d = roff_q + AW'(IN_W);
                        if (r_q == RW'(OW - 1)) begin
                            r_d     = '0;
                            roff_d  = '0;
                            state_d = ACT_EX;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ACT_EX: begin
                if (cnt_q < CW'(NP)) begin
                    l0_rd  = 1'b1;
                    inst_w = 2'b10;
                end
                if (cnt_q == CW'(AEND - 1)) begin
                    cnt_d = '0;
                    if (kij_q == KW'(NK - 1)) begin
                        state_d = OUT_WR;
                    end else begin
                        state_d = WGT_LD;
                        kij_d   = kij_q + 1'b1;
                        wbase_d = wbase_q + AW'(COL);
                        // next kernel row: skip to column 0 of the next input row
                        if (kc_q == KW'(KSIZE - 1)) begin
                            kc_d   = '0;
                            koff_d = koff_q + AW'(OW);
                        end else begin
                            kc_d   = kc_q + 1'b1;
                            koff_d = koff_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT_WR: begin
                o_cen  = 1'b0;
                sfu_rd = 1'b1;
                if (cnt_q == CW'(NP - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // SRAM read data lands in L0 one cycle after the read is issued
        l0_wr_d = rd_issue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            roff_q  <= '0;
            kij_q   <= '0;
            kc_q    <= '0;
            koff_q  <= '0;
            wbase_q <= '0;
            l0_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            roff_q  <= roff_d;
            kij_q   <= kij_d;
            kc_q    <= kc_d;
            koff_q  <= koff_d;
            wbase_q <= wbase_d;
            l0_wr_q <= l0_wr_d;
        end
    end

    assign bus.I_A    = i_a;
    assign bus.I_CEN  = ~rd_issue;
    assign bus.I_WEN  = 1'b1;
    assign bus.l0_wr  = l0_wr_q;
    assign bus.l0_rd  = l0_rd;
    assign bus.inst_w = inst_w;
    assign bus.O_A    = AW'(OUT_BASE) + AW'(cnt_q);
    assign bus.O_CEN  = o_cen;
    assign bus.O_WEN  = o_cen;
    assign bus.sfu_rd = sfu_rd;
    assign bus.kij    = kij_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done;
endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter ROW, default 8, MAC array rows (L0 word lanes).
REQ-002 SHALL have parameter COL, default 8, MAC array columns (weight words per kernel position).
REQ-003 SHALL have parameter KSIZE, default 3, kernel edge; kernel positions NK = KSIZE*KSIZE.
REQ-004 SHALL have parameter IN_W, default 6, input tile edge; OW = IN_W-KSIZE+1; output pixels NP = OW*OW.
REQ-005 SHALL have parameter AW, default 7, SRAM address width.
REQ-006 SHALL have parameter ACT_BASE, default 72, activation region base in input SRAM.
REQ-007 SHALL have parameter OUT_BASE, default 0, psum region base in output SRAM.
REQ-008 SHALL have parameter WDRAIN, default 16, idle cycles after weight injection.
REQ-009 SHALL have parameter ADRAIN, default 18, idle cycles after activation injection.
REQ-010 clk  input  1  clock, all state updates on rising edge.
REQ-011 reset  input  1  asynchronous, active-high.
REQ-012 start  input  1  begin one full convolution tile; sampled in IDLE only.
REQ-013 l0_full  input  1  L0 FIFO full; stalls SRAM read issue.
REQ-014 I_A  output  AW  input SRAM address.
REQ-015 I_CEN  output  1  input SRAM chip enable, active-low.
REQ-016 I_WEN  output  1  input SRAM write enable, active-low; tied 1.
REQ-017 l0_wr  output  1  L0 write strobe.
REQ-018 l0_rd  output  1  L0 read strobe.
REQ-019 inst_w  output  2  MAC instruction: 01 load weight, 10 execute, 00 idle.
REQ-020 O_A  output  AW  output SRAM address.
REQ-021 O_CEN  output  1  output SRAM chip enable, active-low.
REQ-022 O_WEN  output  1  output SRAM write enable, active-low.
REQ-023 sfu_rd  output  1  pops one accumulated psum word from SFU per cycle.
REQ-024 kij  output  ceil(log2 NK)  current kernel position.
REQ-025 busy  output  1  high in any state other than IDLE.
REQ-026 done  output  1  one-cycle pulse at tile completion.

Function
REQ-027 States SHALL be IDLE, WGT_LD, WGT_EX, ACT_LD, ACT_EX, OUT_WR, DONE.
REQ-028 IDLE->WGT_LD on start=1, clearing kij and counters; start ignored in all other states.
REQ-029 WGT_LD SHALL issue COL reads (I_CEN=0), I_A = kij*COL + n, n=0..COL-1; then ->WGT_EX.
REQ-030 ACT_LD SHALL issue NP reads, I_A = ACT_BASE + (kij/KSIZE)*IN_W + kij%KSIZE + r*IN_W + c, pixel n = r*OW + c; then ->ACT_EX.
REQ-031 Address generation SHALL use row/column counters, no dividers; kij row/col offsets tracked incrementally.
REQ-032 A read SHALL issue only when l0_full=0; on l0_full=1, I_CEN=1 and the counter holds.
REQ-033 l0_wr SHALL equal I_CEN-issue delayed one cycle (SRAM read latency 1); last l0_wr of a load may fall in the next state's first cycle.
REQ-034 WGT_EX: COL cycles l0_rd=1, inst_w=01; then WDRAIN cycles inst_w=00, l0_rd=0; then ->ACT_LD.
REQ-035 ACT_EX: NP cycles l0_rd=1, inst_w=10; then ADRAIN cycles inst_w=00; then ->WGT_LD with kij+1 if kij<NK-1, else ->OUT_WR.
REQ-036 Weights SHALL be reloaded for every kij.
REQ-037 OUT_WR: NP cycles O_CEN=0, O_WEN=0, sfu_rd=1, O_A = OUT_BASE + n, n=0..NP-1; then ->DONE.
REQ-038 DONE: done=1 one cycle, ->IDLE; kij holds NK-1 until next start.
REQ-039 Outside their active cycles: I_CEN=1, O_CEN=1, O_WEN=1, l0_wr=0, l0_rd=0, sfu_rd=0, inst_w=00.
REQ-040 Address arithmetic SHALL wrap modulo 2^AW without error.

Reset
REQ-041 On reset: state IDLE, counters 0, kij 0, I_CEN=1, I_WEN=1, O_CEN=1, O_WEN=1, l0_wr=0, l0_rd=0, sfu_rd=0, inst_w=00, busy=0, done=0.
REQ-042 Reset mid-operation SHALL abort immediately to IDLE; no SRAM access after reset assertion edge.

Verification
REQ-043 Defaults, start pulse, l0_full=0 -> kij=0 I_A 0..7 then WGT_EX 8 cycles inst_w=01 then 16 idle; ACT_LD I_A 72,73,74,75,78,79,...,93.
REQ-044 Defaults, kij=4 -> weight I_A 32..39; activation I_A starts 72+7=79, ends 100.
REQ-045 Full run -> 9 kij iterations, OUT_WR O_A 0..15 with sfu_rd=1 16 cycles, single done pulse, busy low after.
REQ-046 l0_full=1 for 3 cycles mid ACT_LD -> I_CEN=1 and I_A frozen 3 cycles; no address skipped or repeated.
REQ-047 reset asserted during ACT_EX of kij=2 -> all outputs to reset values same cycle; new start restarts at kij=0, I_A=0.
REQ-048 start held high throughout -> exactly one tile per IDLE entry; start during busy has no effect.
